// File: rtl/router_spi_pkg.sv
// Shared state encoding and default sizing for the router SPI link.
package router_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        FINISH
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_CNT_W       = 25;
    localparam int DEF_HALF_PERIOD = 49;

endpackage

// File: rtl/spi_bit_shifter.sv
// SPI bit shifter: load/shift register, bit counter and last-bit flag; rx capture when SPI_RX_EN is defined.
// Latency: bit_out follows load/shift by one clock; rx_word updates the cycle after commit is asserted.
// Backpressure: none, strobes come from the owning FSM and are never refused.
module spi_bit_shifter
    import router_spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              bit_out,
    output logic              last
`ifdef SPI_RX_EN
    ,
    input  logic              sample,
    input  logic              miso,
    input  logic              commit,
    output logic [DATA_W-1:0] rx_word
`endif
);

    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] tx_shreg;
    logic [CW-1:0]     bit_cnt;

    // The MSB of the shift register is the bit on the wire, so mosi is a direct flop output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_shreg <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            tx_shreg <= load_data;
            bit_cnt  <= CW'(DATA_W - 1);
        end else if (shift && (bit_cnt != '0)) begin
            tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt - 1'b1;
        end
    end

    assign bit_out = tx_shreg[DATA_W-1];
    assign last    = (bit_cnt == '0);

`ifdef SPI_RX_EN
    logic [DATA_W-1:0] rx_shreg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_shreg <= '0;
            rx_word  <= '0;
        end else begin
            if (sample) begin
                rx_shreg <= {rx_shreg[DATA_W-2:0], miso};
            end
            if (commit) begin
                rx_word <= rx_shreg;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 master transmit stage, MSB first, SCLK paced by an external timebase counter; SPI_RX_EN adds miso capture.
// Latency: csN falls one clock after accept; a frame keeps csN low for 2*DATA_W+1 half-periods, then done pulses.
// Backpressure: txReady is high only in IDLE; txValid while busy is ignored, a word offered during done is taken.
module spi_tx_shifter
    import router_spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              txValid,
    input  logic [DATA_W-1:0] txData,
    output logic              txReady,
    input  logic [CNT_W-1:0]  cntValue,
    output logic              cntEnable,
    output logic              cntClear,
    output logic              sclk,
    output logic              mosi,
    output logic              csN,
    output logic              done
`ifdef SPI_RX_EN
    ,
    input  logic              miso,
    output logic [DATA_W-1:0] rxData
`endif
);

    state_t state, state_nxt;
    logic   sclk_nxt, csn_nxt, enable_nxt, done_nxt;
    logic   load, shift, last;
    logic   tick, accept;

    // The counter sits in clear for the cycle after a tick, so a stale compare there must not count.
    assign tick    = (cntValue == CNT_W'(HALF_PERIOD)) && !cntClear;
    assign txReady = (state == IDLE);
    assign accept  = txValid && txReady;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sclk      <= 1'b0;
            csN       <= 1'b1;
            cntEnable <= 1'b0;
            cntClear  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sclk      <= sclk_nxt;
            csN       <= csn_nxt;
            cntEnable <= enable_nxt;
            cntClear  <= tick || accept;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sclk_nxt   = sclk;
        csn_nxt    = csN;
        enable_nxt = cntEnable;
        done_nxt   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    csn_nxt    = 1'b0;
                    enable_nxt = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_nxt  = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_nxt = 1'b0;
                    if (last) begin
                        state_nxt = FINISH;
                    end else begin
                        shift     = 1'b1;
                        state_nxt = LOW;
                    end
                end
            end
            LOW: begin
                if (tick) begin
                    sclk_nxt  = 1'b1;
                    state_nxt = HIGH;
                end
            end
            FINISH: begin
                if (tick) begin
                    csn_nxt    = 1'b1;
                    enable_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_RX_EN
    logic sample;
    assign sample = tick && ((state == SETUP) || (state == LOW));
`endif

    spi_bit_shifter #(
        .DATA_W (DATA_W)
    ) u_bits (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data (txData),
        .bit_out   (mosi),
        .last      (last)
`ifdef SPI_RX_EN
        ,
        .sample    (sample),
        .miso      (miso),
        .commit    (done_nxt),
        .rx_word   (rxData)
`endif
    );

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Directed bench for spi_tx_shifter with a behavioural timebase counter (HALF_PERIOD=2, four clocks per half-period).
`timescale 1ns/1ps
module tb_spi_tx_shifter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 25;
    localparam int HP     = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              txValid;
    logic [DATA_W-1:0] txData;
    logic              txReady;
    logic [CNT_W-1:0]  cntValue;
    logic              cntEnable, cntClear, sclk, mosi, csN, done;
`ifdef SPI_RX_EN
    logic              miso;
    logic [DATA_W-1:0] rxData;
    logic [7:0]        rx_pat;
    logic [7:0]        f_rx;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] f_bits;
    int         f_rises, f_low, f_done, f_hmin, f_hmax, f_lmin, f_lmax, f_clr_tick, f_rdy_busy;
    logic       f_rdy_at_done, f_csn_before_done;

    always #5 clock = ~clock;

    // Timebase counter with asynchronous clear, as wired on the board.
    always_ff @(posedge clock or posedge cntClear or negedge reset) begin
        if (!reset)         cntValue <= '0;
        else if (cntClear)  cntValue <= '0;
        else if (cntEnable) cntValue <= cntValue + 1'b1;
    end

    spi_tx_shifter #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .HALF_PERIOD (HP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .txValid   (txValid),
        .txData    (txData),
        .txReady   (txReady),
        .cntValue  (cntValue),
        .cntEnable (cntEnable),
        .cntClear  (cntClear),
        .sclk      (sclk),
        .mosi      (mosi),
        .csN       (csN),
        .done      (done)
`ifdef SPI_RX_EN
        ,
        .miso      (miso),
        .rxData    (rxData)
`endif
    );

    // Offer one word at a negedge; returns on the negedge after it was accepted.
    task automatic present(input logic [7:0] word);
        int t = 0;
        while (!txReady && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!txReady) begin
            n_vec++; n_err++;
            $display("FAIL present_ready: txReady=%b required 1", txReady);
        end
        txValid = 1'b1;
        txData  = word;
        @(negedge clock);
        txValid = 1'b0;
    endtask

    // Samples every negedge from the one after accept until done, gathering frame statistics.
    task automatic capture(input bit noise);
        logic prev_sclk, prev_csn;
        int   seg;
        f_bits = '0; f_rises = 0; f_low = 0; f_done = 0;
        f_hmin = 1000; f_hmax = 0; f_lmin = 1000; f_lmax = 0;
        f_clr_tick = 0; f_rdy_busy = 0; f_rdy_at_done = 1'b0; f_csn_before_done = 1'b1;
        prev_sclk = 1'b0; prev_csn = 1'b1; seg = 0;
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                f_done++;
                f_rdy_at_done     = txReady;
                f_csn_before_done = prev_csn;
`ifdef SPI_RX_EN
                f_rx = rxData;
`endif
                break;
            end
            if (!csN) f_low++;
            if (!csN && txReady) f_rdy_busy++;
            if (cntClear && (cntValue == CNT_W'(HP))) f_clr_tick++;
            if (sclk != prev_sclk) begin
                if (prev_sclk) begin
                    if (seg < f_hmin) f_hmin = seg;
                    if (seg > f_hmax) f_hmax = seg;
                end else begin
                    if (seg < f_lmin) f_lmin = seg;
                    if (seg > f_lmax) f_lmax = seg;
                end
                if (sclk) begin
                    f_bits = {f_bits[6:0], mosi};
                    f_rises++;
                end
                seg = 1;
            end else begin
                seg++;
            end
            prev_sclk = sclk;
            prev_csn  = csN;
`ifdef SPI_RX_EN
            if (f_rises < 8) miso = rx_pat[7 - f_rises];
`endif
            if (noise) begin
                if (f_rises < 8) begin
                    txValid = c[0];
                    txData  = 8'(c * 37);
                end else begin
                    txValid = 1'b0;
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; txValid = 1'b0; txData = '0;
        repeat (3) @(negedge clock);
        n_vec++; if (txReady !== 1'b1)   begin n_err++; $display("FAIL reset_txReady: got %b want 1", txReady); end
        n_vec++; if (cntEnable !== 1'b0) begin n_err++; $display("FAIL reset_cntEnable: got %b want 0", cntEnable); end
        n_vec++; if (cntClear !== 1'b0)  begin n_err++; $display("FAIL reset_cntClear: got %b want 0", cntClear); end
        n_vec++; if (sclk !== 1'b0)      begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_vec++; if (mosi !== 1'b0)      begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_vec++; if (csN !== 1'b1)       begin n_err++; $display("FAIL reset_csN: got %b want 1", csN); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_frame();
        present(8'hA5);
        capture(1'b0);
        n_vec++; if (f_bits !== 8'hA5)      begin n_err++; $display("FAIL single_bits: got %h want a5", f_bits); end
        n_vec++; if (f_rises != 8)          begin n_err++; $display("FAIL single_rises: got %0d want 8", f_rises); end
        n_vec++; if (f_low != 68)           begin n_err++; $display("FAIL single_csn_low: got %0d want 68", f_low); end
        n_vec++; if (f_done != 1)           begin n_err++; $display("FAIL single_done: got %0d want 1", f_done); end
        n_vec++; if (f_rdy_at_done !== 1'b1) begin n_err++; $display("FAIL single_ready_at_done: got %b want 1", f_rdy_at_done); end
        @(negedge clock);
        n_vec++; if (done !== 1'b0)         begin n_err++; $display("FAIL single_done_width: got %b want 0", done); end
        n_vec++; if (csN !== 1'b1)          begin n_err++; $display("FAIL single_csn_idle: got %b want 1", csN); end
    endtask

    task automatic test_timing();
        present(8'h3C);
        capture(1'b0);
        n_vec++; if (f_done != 1)      begin n_err++; $display("FAIL timing_done: got %0d want 1", f_done); end
        n_vec++; if (f_hmin != 4 || f_hmax != 4) begin n_err++; $display("FAIL timing_high: got %0d..%0d want 4..4", f_hmin, f_hmax); end
        n_vec++; if (f_lmin != 4 || f_lmax != 4) begin n_err++; $display("FAIL timing_low: got %0d..%0d want 4..4", f_lmin, f_lmax); end
        n_vec++; if (f_clr_tick != 0)  begin n_err++; $display("FAIL timing_tick_in_clear: got %0d want 0", f_clr_tick); end
        n_vec++; if (f_bits !== 8'h3C) begin n_err++; $display("FAIL timing_bits: got %h want 3c", f_bits); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        txValid = 1'b1;
        txData  = 8'hFF;
        @(negedge clock);
        txData  = 8'h00;
        capture(1'b0);
        n_vec++; if (f_bits !== 8'hFF)           begin n_err++; $display("FAIL b2b_first_bits: got %h want ff", f_bits); end
        n_vec++; if (f_rdy_at_done !== 1'b1)     begin n_err++; $display("FAIL b2b_ready_at_done: got %b want 1", f_rdy_at_done); end
        n_vec++; if (f_csn_before_done !== 1'b0) begin n_err++; $display("FAIL b2b_csn_before_done: got %b want 0", f_csn_before_done); end
        @(negedge clock);
        txValid = 1'b0;
        n_vec++; if (csN !== 1'b0)     begin n_err++; $display("FAIL b2b_gap: csN=%b want 0 one clock after done", csN); end
        n_vec++; if (txReady !== 1'b0) begin n_err++; $display("FAIL b2b_second_accepted: txReady=%b want 0", txReady); end
        capture(1'b0);
        n_vec++; if (f_bits !== 8'h00) begin n_err++; $display("FAIL b2b_second_bits: got %h want 00", f_bits); end
        n_vec++; if (f_low != 68)      begin n_err++; $display("FAIL b2b_second_low: got %0d want 68", f_low); end
        n_vec++; if (f_done != 1)      begin n_err++; $display("FAIL b2b_second_done: got %0d want 1", f_done); end
        @(negedge clock);
    endtask

    task automatic test_busy_ignore();
        present(8'hC3);
        capture(1'b1);
        txValid = 1'b0;
        n_vec++; if (f_bits !== 8'hC3) begin n_err++; $display("FAIL busy_bits: got %h want c3", f_bits); end
        n_vec++; if (f_rdy_busy != 0)  begin n_err++; $display("FAIL busy_ready: got %0d busy-ready cycles want 0", f_rdy_busy); end
        n_vec++; if (f_done != 1)      begin n_err++; $display("FAIL busy_done: got %0d want 1", f_done); end
        @(negedge clock);
        n_vec++; if (csN !== 1'b1)     begin n_err++; $display("FAIL busy_no_extra_frame: csN=%b want 1", csN); end
    endtask

    task automatic test_reset_mid();
        int   rises = 0;
        int   t = 0;
        int   dones = 0;
        logic prev = 1'b0;
        present(8'h96);
        while (rises < 3 && t < 300) begin
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises < 3) @(negedge clock);
            t++;
        end
        n_vec++; if (rises != 3) begin n_err++; $display("FAIL abort_reach_bit3: got %0d rises want 3", rises); end
        reset = 1'b0;
        #1;
        n_vec++; if (csN !== 1'b1)       begin n_err++; $display("FAIL abort_csN: got %b want 1", csN); end
        n_vec++; if (sclk !== 1'b0)      begin n_err++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        n_vec++; if (cntEnable !== 1'b0) begin n_err++; $display("FAIL abort_cntEnable: got %b want 0", cntEnable); end
        n_vec++; if (txReady !== 1'b1)   begin n_err++; $display("FAIL abort_txReady: got %b want 1", txReady); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        present(8'h69);
        capture(1'b0);
        n_vec++; if (f_bits !== 8'h69) begin n_err++; $display("FAIL abort_next_bits: got %h want 69", f_bits); end
        n_vec++; if (f_low != 68)      begin n_err++; $display("FAIL abort_next_low: got %0d want 68", f_low); end
        @(negedge clock);
    endtask

`ifdef SPI_RX_EN
    task automatic test_rx();
        rx_pat = 8'h3C;
        miso   = rx_pat[7];
        present(8'h81);
        capture(1'b0);
        n_vec++; if (f_done != 1)    begin n_err++; $display("FAIL rx_done: got %0d want 1", f_done); end
        n_vec++; if (f_rx !== 8'h3C) begin n_err++; $display("FAIL rx_data: got %h want 3c", f_rx); end
        @(negedge clock);
    endtask
`endif

    initial begin
`ifdef SPI_RX_EN
        miso   = 1'b0;
        rx_pat = '0;
        f_rx   = '0;
`endif
        test_reset();
        test_single_frame();
        test_timing();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
`ifdef SPI_RX_EN
        test_rx();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
